trdb_packet_parser: RTL and testbench
=====================================

Name: trdb_packet_parser

Overview:
- Receive end of the trace packet link: takes the byte stream produced after packetisation of emitter output and rebuilds each packet's payload.
- Decodes header fields: format, subformat and sync-start fields.
- Presents one decoded packet at a time to a downstream trace decoder or debug sink over a valid/ready handshake.
- Used in loopback benches and in the off-chip decoder model to check the encoder end to end.

Parameters:
- XLEN, 32, instruction address width.
- PAYLOAD_BYTES, 32, maximum payload bytes per packet; payload register is 8*PAYLOAD_BYTES bits.
- CNT_W, 16, width of the packet and error counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- in_data_i  in  8  stream byte.
- in_valid_i  in  1  byte valid.
- in_ready_o  out  1  parser can accept a byte.
- flush_i  in  1  synchronous abort of the current packet.
- pkt_valid_o  out  1  decoded packet available.
- pkt_ready_i  in  1  consumer accepts the packet.
- pkt_payload_o  out  8*PAYLOAD_BYTES  reassembled payload, zero above the received length.
- pkt_length_o  out  $clog2(PAYLOAD_BYTES)+1  payload length in bytes.
- pkt_format_o  out  2  payload[1:0]; 3=F_SYNC, 2=F_ADDR_ONLY, 1=F_DIFF_DELTA, 0=F_OPT_EXT.
- pkt_subformat_o  out  2  payload[3:2] when format==3, else 0.
- sync_branch_o  out  1  payload[4]; valid only for F_SYNC subformat 0.
- sync_priv_o  out  2  payload[6:5]; valid only for F_SYNC subformat 0.
- sync_addr_o  out  XLEN  payload[XLEN+6:7]; valid only for F_SYNC subformat 0, else 0.
- len_err_o  out  1  one-cycle pulse on an illegal length header.
- pkt_count_o  out  CNT_W  packets delivered, saturating.
- err_count_o  out  CNT_W  length errors, saturating.

Behaviour:
- Framing:
  - Each packet is one header byte L followed by L payload bytes, least significant byte first.
  - Byte k (0-based) goes to payload[8k+7:8k].
  - A byte transfers when in_valid_i && in_ready_o.
- State machine:
  - States: IDLE, COLLECT, OUT.
  - Reset state is IDLE.
  - in_ready_o = 1 in IDLE and COLLECT, 0 in OUT. It is combinational from state.
- IDLE, on a byte transfer:
  - Legal L (1..PAYLOAD_BYTES): latch L, clear the payload register to 0, clear the byte counter, go to COLLECT.
  - Illegal L (0 or >PAYLOAD_BYTES): pulse len_err_o next cycle, increment err_count_o, stay in IDLE.
- COLLECT:
  - Each transfer writes the byte at the counter position and increments the counter.
  - The transfer where counter==L-1 moves to OUT.
  - pkt_valid_o rises on the cycle after the last byte transfer (1-cycle latency).
  - Gaps in in_valid_i are allowed and hold state.
- OUT:
  - pkt_valid_o=1; all pkt_* and sync_* outputs are stable registered values.
  - While pkt_ready_i=0, state and outputs hold.
  - When pkt_ready_i=1: increment pkt_count_o, go to IDLE, drop pkt_valid_o next cycle.
  - No header byte is accepted in the handshake cycle, giving one bubble minimum between packets.
- Field decode:
  - Decoded combinationally from the payload register and exposed only while in OUT.
  - Outside OUT all decoded outputs drive 0.
  - sync_* are 0 unless format==3 and subformat==0.
- flush_i:
  - Any state goes to IDLE next cycle and pkt_valid_o drops.
  - Partial data is discarded; counters are unchanged.
  - flush_i has priority over a simultaneous byte transfer or pkt_ready_i, so that packet is not counted.
- Counters saturate at all ones and never wrap.
- Reset values:
  - in_ready_o=1 (IDLE), pkt_valid_o=0, len_err_o=0.
  - Payload, length, decoded fields and both counters are 0.
  - Reset mid-packet discards everything, same as power-up.

Test Plan:
- Sync start, XLEN=32:
  - Stimulus: send 05,73,00,00,00,40 with pkt_ready_i=1.
  - Required: pkt_valid_o high one cycle after byte 40, format=3, subformat=0, sync_branch_o=1, sync_priv_o=3, sync_addr_o=0x80000000, pkt_length_o=5, pkt_count_o=1.
- Back-pressure:
  - Stimulus: send 02,AA,55 with pkt_ready_i=0 for 5 cycles, then 1.
  - Required: payload=0x55AA held stable; in_ready_o=0 during OUT; format=2 (0xAA[1:0]); sync_* = 0; count increments only at the handshake.
- Illegal length:
  - Stimulus: send header 00, then header 21 (33 bytes).
  - Required: two len_err_o pulses, err_count_o=2, state stays IDLE; a following 01,03 packet decodes with format=3, subformat=0.
- Flush mid-packet:
  - Stimulus: send 04,11,22, assert flush_i, then send 01,01.
  - Required: no packet for the aborted frame; next packet payload=0x01 with upper bytes 0, format=1, pkt_count_o=1.
- Gapped input and max length:
  - Stimulus: send PAYLOAD_BYTES=32 bytes 0x00..0x1F with in_valid_i toggling every cycle.
  - Required: payload byte k = k, pkt_length_o=32.
- Reset and saturation:
  - Stimulus: rst_i asserted mid-COLLECT; separately force 0xFFFF packets and deliver one more.
  - Required: all outputs return to reset values; pkt_count_o stays 0xFFFF.

Source files
------------

// File: rtl/trdb_packet_parser.sv
// Trace packet link receiver: rebuilds length-prefixed packets from a byte stream
// and presents them, with decoded header fields, over a valid/ready handshake.
module trdb_packet_parser #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned PAYLOAD_BYTES = 32,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [7:0]                         in_data_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic                               flush_i,
  output logic                               pkt_valid_o,
  input  logic                               pkt_ready_i,
  output logic [8*PAYLOAD_BYTES-1:0]         pkt_payload_o,
  output logic [$clog2(PAYLOAD_BYTES):0]     pkt_length_o,
  output logic [1:0]                         pkt_format_o,
  output logic [1:0]                         pkt_subformat_o,
  output logic                               sync_branch_o,
  output logic [1:0]                         sync_priv_o,
  output logic [XLEN-1:0]                    sync_addr_o,
  output logic                               len_err_o,
  output logic [CNT_W-1:0]                   pkt_count_o,
  output logic [CNT_W-1:0]                   err_count_o
);

  localparam int unsigned LW = $clog2(PAYLOAD_BYTES) + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, OUT} state_t;

  state_t                     state, state_next;
  logic [8*PAYLOAD_BYTES-1:0] payload;
  logic [LW-1:0]              len;
  logic [LW-1:0]              cnt;
  logic                       len_err;
  logic [CNT_W-1:0]           pkt_count;
  logic [CNT_W-1:0]           err_count;
  logic                       xfer;
  logic                       hdr_legal;
  logic                       last_byte;

  always_comb begin
    in_ready_o = (state != OUT);
    xfer       = in_valid_i && in_ready_o;
    hdr_legal  = (in_data_i != 8'd0) && (32'(in_data_i) <= PAYLOAD_BYTES);
    last_byte  = (cnt == len - LW'(1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (xfer && hdr_legal) state_next = COLLECT;
      COLLECT: if (xfer && last_byte) state_next = OUT;
      OUT:     if (pkt_ready_i)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  // flush_i suppresses every datapath update, so an aborted handshake is never counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      payload   <= '0;
      len       <= '0;
      cnt       <= '0;
      len_err   <= 1'b0;
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      len_err <= 1'b0;
      if (!flush_i) begin
        unique case (state)
          IDLE: begin
            if (xfer) begin
              if (hdr_legal) begin
                len     <= in_data_i[LW-1:0];
                payload <= '0;
                cnt     <= '0;
              end else begin
                len_err <= 1'b1;
                if (err_count != '1) err_count <= err_count + 1'b1;
              end
            end
          end
          COLLECT: begin
            if (xfer) begin
              payload[{cnt, 3'b000} +: 8] <= in_data_i;
              cnt                         <= cnt + 1'b1;
            end
          end
          OUT: begin
            if (pkt_ready_i && pkt_count != '1) pkt_count <= pkt_count + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    pkt_valid_o     = 1'b0;
    pkt_payload_o   = '0;
    pkt_length_o    = '0;
    pkt_format_o    = '0;
    pkt_subformat_o = '0;
    sync_branch_o   = 1'b0;
    sync_priv_o     = '0;
    sync_addr_o     = '0;
    if (state == OUT) begin
      pkt_valid_o   = 1'b1;
      pkt_payload_o = payload;
      pkt_length_o  = len;
      pkt_format_o  = payload[1:0];
      if (payload[1:0] == 2'b11) begin
        pkt_subformat_o = payload[3:2];
        if (payload[3:2] == 2'b00) begin
          sync_branch_o = payload[4];
          sync_priv_o   = payload[6:5];
          sync_addr_o   = payload[XLEN+6:7];
        end
      end
    end
    len_err_o   = len_err;
    pkt_count_o = pkt_count;
    err_count_o = err_count;
  end

endmodule

// File: tb/tb_trdb_packet_parser.sv
// Bench for trdb_packet_parser: directed scenarios plus random packets checked
// against a byte-list reference model; a narrow-counter instance covers saturation.
module tb_trdb_packet_parser;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PB   = 32;
  localparam int unsigned LW   = $clog2(PB) + 1;

  typedef logic [7:0] bq_t[$];

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              rst_i, in_valid_i, flush_i, pkt_ready_i;
  logic [7:0]        in_data_i;
  logic              in_ready_o, pkt_valid_o, sync_branch_o, len_err_o;
  logic [8*PB-1:0]   pkt_payload_o;
  logic [LW-1:0]     pkt_length_o;
  logic [1:0]        pkt_format_o, pkt_subformat_o, sync_priv_o;
  logic [XLEN-1:0]   sync_addr_o;
  logic [15:0]       pkt_count_o, err_count_o;

  logic              s_rst, s_in_valid, s_flush, s_pkt_ready;
  logic [7:0]        s_in_data;
  logic              s_in_ready, s_pkt_valid, s_branch, s_len_err;
  logic [8*PB-1:0]   s_payload;
  logic [LW-1:0]     s_length;
  logic [1:0]        s_format, s_subformat, s_priv;
  logic [XLEN-1:0]   s_addr;
  logic [3:0]        s_pkt_count, s_err_count;

  trdb_packet_parser #(.XLEN(XLEN), .PAYLOAD_BYTES(PB), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .flush_i(flush_i), .pkt_valid_o(pkt_valid_o),
    .pkt_ready_i(pkt_ready_i), .pkt_payload_o(pkt_payload_o), .pkt_length_o(pkt_length_o),
    .pkt_format_o(pkt_format_o), .pkt_subformat_o(pkt_subformat_o),
    .sync_branch_o(sync_branch_o), .sync_priv_o(sync_priv_o), .sync_addr_o(sync_addr_o),
    .len_err_o(len_err_o), .pkt_count_o(pkt_count_o), .err_count_o(err_count_o));

  trdb_packet_parser #(.XLEN(XLEN), .PAYLOAD_BYTES(PB), .CNT_W(4)) dut_sat (
    .clk_i(clk_i), .rst_i(s_rst), .in_data_i(s_in_data), .in_valid_i(s_in_valid),
    .in_ready_o(s_in_ready), .flush_i(s_flush), .pkt_valid_o(s_pkt_valid),
    .pkt_ready_i(s_pkt_ready), .pkt_payload_o(s_payload), .pkt_length_o(s_length),
    .pkt_format_o(s_format), .pkt_subformat_o(s_subformat),
    .sync_branch_o(s_branch), .sync_priv_o(s_priv), .sync_addr_o(s_addr),
    .len_err_o(s_len_err), .pkt_count_o(s_pkt_count), .err_count_o(s_err_count));

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  logic [15:0] exp_pkts, exp_errs;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int unsigned n;
    if (gap) begin
      in_valid_i = 1'b0;
      tick();
    end
    in_data_i  = b;
    in_valid_i = 1'b1;
    n = 0;
    while (!in_ready_o && n < 200) begin
      tick();
      n++;
    end
    compared++;
    assert (n < 200) else begin
      mismatched++;
      $error("FAIL send_timeout got=%0d exp<200", n);
    end
    tick();
    in_valid_i = 1'b0;
  endtask

  function automatic logic [255:0] model_payload(input bq_t q);
    logic [255:0] p;
    p = '0;
    foreach (q[k]) p = p | (256'(q[k]) << (8 * k));
    return p;
  endfunction

  task automatic check_out(input bq_t q, input string tag);
    logic [255:0] p;
    int unsigned  fmt, sub;
    bit           is_sync;
    p       = model_payload(q);
    fmt     = q[0] % 4;
    sub     = (fmt == 3) ? (q[0] / 4) % 4 : 0;
    is_sync = (fmt == 3) && (sub == 0);
    chk({tag, "_valid"},   pkt_valid_o, 1);
    chk({tag, "_inready"}, in_ready_o, 0);
    chk({tag, "_payload"}, pkt_payload_o, p);
    chk({tag, "_length"},  pkt_length_o, q.size());
    chk({tag, "_format"},  pkt_format_o, fmt);
    chk({tag, "_subfmt"},  pkt_subformat_o, sub);
    chk({tag, "_branch"},  sync_branch_o, is_sync ? (q[0] / 16) % 2 : 0);
    chk({tag, "_priv"},    sync_priv_o, is_sync ? (q[0] / 32) % 4 : 0);
    chk({tag, "_addr"},    sync_addr_o, is_sync ? ((p >> 7) & 256'hFFFF_FFFF) : 0);
  endtask

  // gapmode: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random gaps
  task automatic run_pkt(input bq_t q, input int unsigned hold, input int unsigned gapmode,
                         input string tag);
    send(8'(q.size()), gapmode == 1 || (gapmode == 2 && $urandom % 3 == 0));
    foreach (q[k]) send(q[k], gapmode == 1 || (gapmode == 2 && $urandom % 3 == 0));
    check_out(q, tag);
    for (int unsigned i = 0; i < hold; i++) begin
      pkt_ready_i = 1'b0;
      tick();
      chk({tag, "_hold_payload"}, pkt_payload_o, model_payload(q));
      chk({tag, "_hold_valid"},   pkt_valid_o, 1);
      chk({tag, "_hold_count"},   pkt_count_o, exp_pkts);
    end
    pkt_ready_i = 1'b1;
    tick();
    pkt_ready_i = 1'b0;
    if (exp_pkts != 16'hFFFF) exp_pkts++;
    chk({tag, "_done_valid"}, pkt_valid_o, 0);
    chk({tag, "_done_count"}, pkt_count_o, exp_pkts);
    chk({tag, "_done_rdy"},   in_ready_o, 1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_inready"}, in_ready_o, 1);
    chk({tag, "_valid"},   pkt_valid_o, 0);
    chk({tag, "_lenerr"},  len_err_o, 0);
    chk({tag, "_payload"}, pkt_payload_o, 0);
    chk({tag, "_length"},  pkt_length_o, 0);
    chk({tag, "_format"},  pkt_format_o, 0);
    chk({tag, "_addr"},    sync_addr_o, 0);
    chk({tag, "_pkts"},    pkt_count_o, 0);
    chk({tag, "_errs"},    err_count_o, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t         q;
    logic [7:0]  b;
    int unsigned len;

    rst_i = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0; pkt_ready_i = 1'b0; in_data_i = '0;
    s_rst = 1'b1; s_in_valid = 1'b0; s_flush = 1'b0; s_pkt_ready = 1'b0; s_in_data = '0;
    exp_pkts = '0;
    exp_errs = '0;
    tick();
    tick();
    check_reset_state("reset");
    rst_i = 1'b0;
    s_rst = 1'b0;
    tick();

    // Sync start packet: 05,73,00,00,00,40
    q = '{8'h73, 8'h00, 8'h00, 8'h00, 8'h40};
    send(8'h05, 0);
    foreach (q[k]) send(q[k], 0);
    chk("sync_addr_const", sync_addr_o, 32'h8000_0000);
    chk("sync_priv_const", sync_priv_o, 3);
    check_out(q, "sync");
    pkt_ready_i = 1'b1;
    tick();
    pkt_ready_i = 1'b0;
    exp_pkts++;
    chk("sync_count", pkt_count_o, 1);

    // Back-pressure
    q = '{8'hAA, 8'h55};
    run_pkt(q, 5, 0, "bp");
    chk("bp_count_const", pkt_count_o, 2);

    // Illegal lengths
    send(8'h00, 0);
    exp_errs++;
    chk("len0_pulse", len_err_o, 1);
    chk("len0_errs", err_count_o, exp_errs);
    send(8'h21, 0);
    exp_errs++;
    chk("len33_pulse", len_err_o, 1);
    chk("len33_errs", err_count_o, 2);
    tick();
    chk("lenerr_clear", len_err_o, 0);
    chk("lenerr_idle_valid", pkt_valid_o, 0);
    chk("lenerr_idle_rdy", in_ready_o, 1);
    q = '{8'h03};
    run_pkt(q, 0, 0, "after_err");

    // Flush mid-packet
    send(8'h04, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_valid", pkt_valid_o, 0);
    chk("flush_rdy", in_ready_o, 1);
    chk("flush_count", pkt_count_o, exp_pkts);
    q = '{8'h01};
    run_pkt(q, 0, 0, "post_flush");

    // Flush wins over a simultaneous handshake
    send(8'h01, 0);
    send(8'h05, 0);
    chk("flush_hs_pre", pkt_valid_o, 1);
    pkt_ready_i = 1'b1;
    flush_i     = 1'b1;
    tick();
    pkt_ready_i = 1'b0;
    flush_i     = 1'b0;
    chk("flush_hs_valid", pkt_valid_o, 0);
    chk("flush_hs_count", pkt_count_o, exp_pkts);

    // Max length with gapped input
    q = {};
    for (int unsigned k = 0; k < PB; k++) q.push_back(8'(k));
    run_pkt(q, 1, 1, "maxlen");

    // Random traffic
    for (int unsigned it = 0; it < 40; it++) begin
      if ($urandom % 5 == 0) begin
        b = ($urandom % 2 == 0) ? 8'h00 : 8'($urandom_range(33, 255));
        send(b, 0);
        if (exp_errs != 16'hFFFF) exp_errs++;
        chk("rnd_lenerr", len_err_o, 1);
        chk("rnd_errs", err_count_o, exp_errs);
      end
      len = $urandom_range(1, PB);
      q = {};
      for (int unsigned k = 0; k < len; k++) q.push_back(8'($urandom));
      run_pkt(q, $urandom_range(0, 3), 2, "rnd");
    end

    // Reset mid-COLLECT
    send(8'h03, 0);
    send(8'hAA, 0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_pkts = '0;
    exp_errs = '0;
    check_reset_state("midreset");
    q = '{8'h5B, 8'hC3};
    run_pkt(q, 0, 0, "post_reset");

    // Counter saturation on the 4-bit instance
    for (int unsigned i = 0; i < 20; i++) begin
      s_in_data  = 8'd1;
      s_in_valid = 1'b1;
      tick();
      s_in_data = 8'(i);
      tick();
      s_in_valid  = 1'b0;
      s_pkt_ready = 1'b1;
      tick();
      s_pkt_ready = 1'b0;
      if (i == 14 || i == 19) chk("sat_pkts", s_pkt_count, (i + 1 < 15) ? i + 1 : 15);
    end
    for (int unsigned i = 0; i < 20; i++) begin
      s_in_data  = 8'd0;
      s_in_valid = 1'b1;
      tick();
      if (i == 14 || i == 19) chk("sat_errs", s_err_count, (i + 1 < 15) ? i + 1 : 15);
    end
    s_in_valid = 1'b0;
    tick();
    chk("sat_pkts_final", s_pkt_count, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
